fb_clear_sequencer: RTL

//  Upstream feeder for the framebuffer write port. Per frame, it first sweeps every pixel with a forced

---
 rtl/fb_pkg.sv | 28 ++
 rtl/evt_counter.sv | 30 +++
 rtl/fb_clear_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants, also used by the framebuffer and rasterizer.
package fb_pkg;

  localparam int FB_HRES   = 320;
  localparam int FB_VRES   = 180;
  localparam int FB_DEPTH  = FB_HRES * FB_VRES;
  localparam int FB_ADDR_W = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PASS  = 2'd2,
    FLIP  = 2'd3
  } fb_seq_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Row-major linear pixel address; hres is a constant so this folds into a constant multiply.
  function automatic logic [FB_ADDR_W-1:0] fb_lin_addr(input logic [8:0] h, input logic [7:0] v,
                                                       input int hres);
    return FB_ADDR_W'(v) * FB_ADDR_W'(hres) + FB_ADDR_W'(h);
  endfunction

endpackage

// File: rtl/evt_counter.sv
// Event counter that wraps after MAX_COUNT events; at_last flags the final count value.
module evt_counter
  import fb_pkg::*;
#(
  parameter int MAX_COUNT = FB_DEPTH,
  parameter int W         = FB_ADDR_W
) (
  input  logic         clk_100_passthrough,
  input  logic         srst,
  input  logic         clr,
  input  logic         evt_in,
  output logic [W-1:0] count,
  output logic         at_last
);

  logic [W-1:0] count_reg;

  assign count   = count_reg;
  assign at_last = (count_reg == W'(MAX_COUNT - 1));

  // Count events; clear restarts the sweep from zero.
  always_ff @(posedge clk_100_passthrough) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (evt_in) begin
      count_reg <= at_last ? '0 : count_reg + W'(1);
    end
  end

endmodule

// File: rtl/fb_clear_sequencer.sv
// Per-frame feeder for the framebuffer write port: clear sweep, fragment pass-through, frame flip.
module fb_clear_sequencer
  import fb_pkg::*;
#(
  parameter int                 Z_WIDTH     = 15,
  parameter int                 HRES        = 320,
  parameter int                 VRES        = 180,
  parameter logic [15:0]        CLEAR_COLOR = 16'h0000,
  parameter logic [Z_WIDTH-1:0] CLEAR_DEPTH = '1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_start_in,
  input  logic                 frag_valid_in,
  output logic                 frag_ready_out,
  input  logic [8:0]           frag_h_in,
  input  logic [7:0]           frag_v_in,
  input  logic [Z_WIDTH-1:0]   frag_depth_in,
  input  logic [15:0]          frag_color_in,
  input  logic                 frag_last_in,
  input  logic                 fb_ready_in,
  output logic                 fb_valid_out,
  output logic [FB_ADDR_W-1:0] fb_addr_out,
  output logic [Z_WIDTH-1:0]   fb_depth_out,
  output logic [15:0]          fb_color_out,
  output logic                 fb_clear_out,
  output logic                 fb_frame_out,
  output logic                 busy_out,
  output logic [15:0]          drop_count_out
);

  localparam int DEPTH = HRES * VRES;

  fb_seq_state_t        state_reg, state_next;
  logic                 pending_reg, pending_next;
  logic                 valid_reg, clear_reg, frame_reg;
  logic [FB_ADDR_W-1:0] addr_reg;
  logic [Z_WIDTH-1:0]   depth_reg;
  rgb565_t              color_reg;
  logic [15:0]          drop_reg;

  logic                 adv;
  logic                 start_clear;
  logic                 load_clear, load_frag, drop_frag, frame_toggle, frag_ready;
  logic [FB_ADDR_W-1:0] clear_cnt;
  logic                 clear_at_last;

  // Output stage may take a new word when empty or when the framebuffer consumes the current one.
  assign adv         = !valid_reg || fb_ready_in;
  assign start_clear = (state_reg == IDLE) && (frame_start_in || pending_reg);

  evt_counter #(
    .MAX_COUNT(DEPTH),
    .W        (FB_ADDR_W)
  ) u_clear_cnt (
    .clk_100_passthrough(clk_in),
    .srst               (rst_in),
    .clr                (start_clear),
    .evt_in             ((state_reg == CLEAR) && adv),
    .count              (clear_cnt),
    .at_last            (clear_at_last)
  );

  // State register and pending-start flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  // Next-state logic and per-cycle load/drop decisions.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    frag_ready   = 1'b0;
    load_clear   = 1'b0;
    load_frag    = 1'b0;
    drop_frag    = 1'b0;
    frame_toggle = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start_in || pending_reg) begin
          state_next   = CLEAR;
          pending_next = 1'b0;
        end
      end
      CLEAR: begin
        if (adv) begin
          load_clear = 1'b1;
          if (clear_at_last) state_next = PASS;
        end
      end
      PASS: begin
        frag_ready = adv;
        if (frag_valid_in && adv) begin
          if ((int'(frag_h_in) < HRES) && (int'(frag_v_in) < VRES)) load_frag = 1'b1;
          else drop_frag = 1'b1;
          if (frag_last_in) state_next = FLIP;
        end
      end
      FLIP: begin
        if (adv) begin
          frame_toggle = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A start request outside IDLE is remembered and serviced on the next IDLE cycle.
    if ((state_reg != IDLE) && frame_start_in) pending_next = 1'b1;
  end

  // Output register: holds under backpressure, drops valid when advancing with nothing to load.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      depth_reg <= '0;
      color_reg <= '0;
      clear_reg <= 1'b0;
      frame_reg <= 1'b0;
      drop_reg  <= '0;
    end else begin
      if (adv) begin
        valid_reg <= load_clear || load_frag;
        if (load_clear) begin
          addr_reg  <= clear_cnt;
          depth_reg <= CLEAR_DEPTH;
          color_reg <= rgb565_t'(CLEAR_COLOR);
          clear_reg <= 1'b1;
        end else if (load_frag) begin
          addr_reg  <= fb_lin_addr(frag_h_in, frag_v_in, HRES);
          depth_reg <= frag_depth_in;
          color_reg <= rgb565_t'(frag_color_in);
          clear_reg <= 1'b0;
        end
      end
      if (frame_toggle) frame_reg <= ~frame_reg;
      if (drop_frag && (drop_reg != 16'hFFFF)) drop_reg <= drop_reg + 16'd1;
    end
  end

  assign frag_ready_out = frag_ready;
  assign fb_valid_out   = valid_reg;
  assign fb_addr_out    = addr_reg;
  assign fb_depth_out   = depth_reg;
  assign fb_color_out   = color_reg;
  assign fb_clear_out   = clear_reg;
  assign fb_frame_out   = frame_reg;
  assign busy_out       = (state_reg != IDLE);
  assign drop_count_out = drop_reg;

endmodule
